fifo_avg_sequencer: RTL and testbench

- Sequencer that drives a fifo_ctrl-managed register-file window to implement an N-point running-average filter on an audio sample stream.
- Each accepted sample is pre-scaled by 1/N, pushed into the window FIFO and added to a running accumulator.
- Once the window is full, the oldest sample is popped in the same cycle and subtracted from the accumulator.
- Sits between the codec sample interface and the filter output. It is the only agent that asserts rd/wr on the window FIFO.

---
 rtl/fifo_avg_sequencer_pkg.sv | 17 +
 rtl/fifo_avg_sequencer_if.sv | 28 ++
 rtl/fifo_avg_sequencer_avg_accum.sv | 21 ++
 rtl/fifo_avg_sequencer.sv | 111 +++++++++++
 tb/tb_fifo_avg_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_avg_sequencer_pkg.sv
// Shared types and sizing helpers for the running-average sequencer.
package fifo_avg_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int DEFAULT_DATA_WIDTH = 24;
   localparam int DEFAULT_ADDR_WIDTH = 3;

   function automatic int depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/fifo_avg_sequencer_if.sv
// Sample stream, window-FIFO request and filter-output signals of the sequencer.
interface fifo_avg_sequencer_if #(
   parameter int DATA_WIDTH = 24
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  flush;
   logic                  fifo_rd;
   logic                  fifo_wr;
   logic [DATA_WIDTH-1:0] fifo_wdata;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  flush_done;

   modport master (
      input  in_valid, in_data, flush, fifo_rdata, fifo_empty, fifo_full,
      output in_ready, fifo_rd, fifo_wr, fifo_wdata, out_valid, out_data, flush_done
   );

   modport slave (
      output in_valid, in_data, flush, fifo_rdata, fifo_empty, fifo_full,
      input  in_ready, fifo_rd, fifo_wr, fifo_wdata, out_valid, out_data, flush_done
   );
endinterface

// File: rtl/fifo_avg_sequencer_avg_accum.sv
// Registered window accumulator: acc <= acc + add_term - sub_term, wrapping.
module avg_accum #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic [W-1:0] add_term,
   input  logic [W-1:0] sub_term,
   output logic [W-1:0] acc,
   output logic [W-1:0] acc_next
);

   assign acc_next = acc + add_term - sub_term;

   always_ff @(posedge clk) begin
      if (reset || clr) acc <= '0;
      else              acc <= acc_next;
   end

endmodule

// File: rtl/fifo_avg_sequencer.sv
// Running-average sequencer: owns the window FIFO requests, accumulator and output register.
module fifo_avg_sequencer
   import fifo_avg_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input logic clk,
   input logic reset,
   fifo_avg_sequencer_if.master bus
);

   localparam int N  = depth(ADDR_WIDTH);
   localparam int CW = ADDR_WIDTH + 1;

   state_t                state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [DATA_WIDTH-1:0] xs, add_term, sub_term, acc, acc_next, out_data;
   logic                  ready, accept, clr, fire, done, rd, wr;
   logic                  out_valid, flush_done;

   assign xs     = DATA_WIDTH'($signed(bus.in_data) >>> ADDR_WIDTH);
   assign ready  = (state != FLUSH) && !bus.flush;
   assign accept = bus.in_valid && ready;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      rd       = 1'b0;
      wr       = 1'b0;
      add_term = '0;
      sub_term = '0;
      clr      = 1'b0;
      fire     = 1'b0;
      done     = 1'b0;
      unique case (state)
         FILL: begin
            if (bus.flush) begin
               state_n = FLUSH;
            end else if (accept) begin
               wr       = 1'b1;
               add_term = xs;
               cnt_n    = cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state_n = RUN;
                  fire    = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.flush) begin
               state_n = FLUSH;
            end else if (accept) begin
               rd       = 1'b1;
               wr       = 1'b1;
               add_term = xs;
               sub_term = bus.fifo_rdata;
               fire     = 1'b1;
            end
         end
         FLUSH: begin
            // fifo_empty is registered, so it only rises after the final pop lands
            if (!bus.fifo_empty) begin
               rd       = 1'b1;
               sub_term = bus.fifo_rdata;
            end else begin
               clr     = 1'b1;
               cnt_n   = '0;
               done    = 1'b1;
               state_n = FILL;
            end
         end
         default: state_n = FILL;
      endcase
   end

   avg_accum #(.W(DATA_WIDTH)) u_accum (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .add_term (add_term),
      .sub_term (sub_term),
      .acc      (acc),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FILL;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         flush_done <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         out_valid  <= fire;
         flush_done <= done;
         if (fire) out_data <= acc_next;
      end
   end

   assign bus.in_ready   = ready;
   assign bus.fifo_rd    = rd && !reset;
   assign bus.fifo_wr    = wr && !reset;
   assign bus.fifo_wdata = xs;
   assign bus.out_valid  = out_valid;
   assign bus.out_data   = out_data;
   assign bus.flush_done = flush_done;

endmodule

// File: tb/tb_fifo_avg_sequencer.sv
// Directed bench for fifo_avg_sequencer with a window-FIFO model and a reference-window scoreboard.
module tb_fifo_avg_sequencer;

   localparam int DW = 24;
   localparam int AW = 3;
   localparam int N  = 8;

   logic clk;
   logic reset;

   fifo_avg_sequencer_if #(.DATA_WIDTH(DW)) bus ();

   fifo_avg_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // window FIFO: combinational read data, registered flags
   logic [DW-1:0] mem [N];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   count, nc;

   assign bus.fifo_rdata = mem[rp];
   always_comb nc = count + (AW+1)'(bus.fifo_wr) - (AW+1)'(bus.fifo_rd);

   always @(posedge clk) begin
      if (reset) begin
         wp             <= '0;
         rp             <= '0;
         count          <= '0;
         bus.fifo_empty <= 1'b1;
         bus.fifo_full  <= 1'b0;
      end else begin
         if (bus.fifo_wr) begin
            mem[wp] <= bus.fifo_wdata;
            wp      <= wp + 1'b1;
         end
         if (bus.fifo_rd) rp <= rp + 1'b1;
         count          <= nc;
         bus.fifo_empty <= (nc == 0);
         bus.fifo_full  <= (nc == (AW+1)'(N));
      end
   end

   int passes = 0;
   int checks = 0;
   int ov_cnt, rd_cnt, wr_cnt, pair_cnt, done_cnt, acc_cnt;
   int viol = 0;
   logic [DW-1:0] wq[$];
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // scoreboard: expected average is the plain sum of the last N scaled samples
   always @(negedge clk) begin
      if (reset) begin
         wq.delete();
         exp_q.delete();
      end else begin
         if (bus.out_valid) begin
            ov_cnt++;
            chk("out_valid_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
         end
         if (bus.fifo_rd) rd_cnt++;
         if (bus.fifo_wr) wr_cnt++;
         if (bus.fifo_rd && bus.fifo_wr) pair_cnt++;
         if (bus.flush_done) done_cnt++;
         if ((bus.fifo_wr && !bus.fifo_rd && bus.fifo_full) || (bus.fifo_rd && bus.fifo_empty))
            viol++;
         if (bus.flush) begin
            wq.delete();
         end else if (bus.in_valid && bus.in_ready) begin
            logic signed [DW-1:0] s;
            logic [DW-1:0] sum;
            acc_cnt++;
            s = $signed(bus.in_data) >>> AW;
            if (wq.size() == N) void'(wq.pop_front());
            wq.push_back(s);
            if (wq.size() == N) begin
               sum = '0;
               foreach (wq[i]) sum = sum + wq[i];
               exp_q.push_back(sum);
            end
         end
      end
   end

   task automatic clr_counts();
      ov_cnt = 0; rd_cnt = 0; wr_cnt = 0; pair_cnt = 0; done_cnt = 0; acc_cnt = 0;
   endtask

   task automatic send(input logic [DW-1:0] x);
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (done_cnt == 0 && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(done_cnt > 0), 32'd1);
      idle(1);
   endtask

   initial begin
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.flush    = 1'b0;
      clr_counts();
      idle(2);
      // requests must stay low under reset even with a sample offered
      bus.in_valid = 1'b1;
      bus.in_data  = 24'd800;
      #1;
      chk("wr_in_reset", 32'(bus.fifo_wr), 32'd0);
      chk("rd_in_reset", 32'(bus.fifo_rd), 32'd0);
      bus.in_valid = 1'b0;
      idle(1);
      reset = 1'b0;
      idle(1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // fill the window with 800s
      clr_counts();
      for (int i = 0; i < 7; i++) send(24'd800);
      idle(1);
      chk("fill_no_out", 32'(ov_cnt), 32'd0);
      send(24'd800);
      idle(1);
      chk("fill_out_cnt", 32'(ov_cnt), 32'd1);
      chk("fill_out_data", 32'(bus.out_data), 32'd800);
      chk("fill_full", 32'(bus.fifo_full), 32'd1);

      // decay with zeros: 700 .. 0
      clr_counts();
      for (int i = 0; i < 8; i++) send(24'd0);
      idle(1);
      chk("run_out_cnt", 32'(ov_cnt), 32'd8);
      chk("run_pairs", 32'(pair_cnt), 32'd8);
      chk("run_rd_cnt", 32'(rd_cnt), 32'd8);
      chk("run_wr_cnt", 32'(wr_cnt), 32'd8);
      chk("run_last", 32'(bus.out_data), 32'd0);

      // negative samples
      do_reset();
      for (int i = 0; i < 8; i++) send(-24'sd800);
      idle(1);
      chk("neg_avg", 32'(bus.out_data), 32'h00FFFCE0);
      send(24'd8);
      idle(1);
      chk("neg_step", 32'(bus.out_data), 32'h00FFFD45);

      // partial window then flush
      do_reset();
      for (int i = 0; i < 3; i++) send(24'd80);
      clr_counts();
      bus.flush = 1'b1;
      idle(1);
      bus.flush = 1'b0;
      wait_done("flush3_done");
      chk("flush3_rd_cnt", 32'(rd_cnt), 32'd3);
      chk("flush3_done_cnt", 32'(done_cnt), 32'd1);
      chk("flush3_empty", 32'(bus.fifo_empty), 32'd1);
      clr_counts();
      for (int i = 0; i < 7; i++) send(24'd80);
      idle(1);
      chk("refill_no_out", 32'(ov_cnt), 32'd0);
      send(24'd80);
      idle(1);
      chk("refill_out_cnt", 32'(ov_cnt), 32'd1);
      chk("refill_acc_clear", 32'(bus.out_data), 32'd80);

      // flush and sample in the same cycle while in RUN
      clr_counts();
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 24'd800;
      #1;
      chk("flush_prio_ready", 32'(bus.in_ready), 32'd0);
      idle(1);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      wait_done("flush8_done");
      chk("flush8_rd_cnt", 32'(rd_cnt), 32'd8);
      chk("flush8_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("flush8_empty", 32'(bus.fifo_empty), 32'd1);

      // reset in the middle of RUN
      for (int i = 0; i < 10; i++) send(24'd160);
      do_reset();
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_data", 32'(bus.out_data), 32'd0);
      chk("mid_rst_empty", 32'(bus.fifo_empty), 32'd1);
      clr_counts();
      for (int i = 0; i < 7; i++) send(24'd80);
      idle(1);
      chk("resume_no_out", 32'(ov_cnt), 32'd0);
      send(24'd80);
      idle(1);
      chk("resume_out_cnt", 32'(ov_cnt), 32'd1);
      chk("resume_data", 32'(bus.out_data), 32'd80);

      idle(2);
      chk("fifo_invariants", 32'(viol), 32'd0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
